gate_exerciser: RTL and testbench
=================================

# gate_exerciser

Self-checking stimulus/response stage for a 2-input combinational gate under test. After a start pulse it drives all four input combinations {a,b} = 00, 01, 10, 11 into the gate, holding each for a programmable dwell. It samples the gate output at the end of each dwell and compares it against an expected 4-bit truth table. It sits directly upstream of the gate (driving its a/b inputs) and consumes the gate output, reporting pass/fail, an error count and a per-vector fail mask.

## Interface
- DWELL, default 4: cycles each vector is held; legal range 2..256.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a run; ignored while busy.
- exp_tt  in  4  expected output; bit index = {a,b} (bit0 = 00, bit3 = 11); latched on accepted start.
- y_in  in  1  output of the gate under test (combinational from a_out/b_out).
- a_out  out  1  gate input a (registered).
- b_out  out  1  gate input b (registered).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  valid from done onward; 1 when err_count == 0; held until next accepted start.
- err_count  out  3  number of mismatching vectors, 0..4.
- fail_mask  out  4  bit k set when vector k mismatched.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - a_out = b_out = 0, busy = 0.
  - start = 1 → latch exp_tt, clear err_count and fail_mask, clear pass, set vec = 0 and dwell_cnt = 0, go to RUN.
- RUN:
  - {a_out,b_out} = vec; busy = 1; dwell_cnt increments each cycle.
  - When dwell_cnt == DWELL-1, sample y_in and compare it with tt[vec].
  - On mismatch: set fail_mask[vec] and increment err_count.
  - If vec == 3, go to DONE. Otherwise vec + 1 and dwell_cnt = 0.
- DONE:
  - done = 1 for exactly one cycle; pass = (err_count == 0).
  - busy = 0; a_out/b_out return to 0; next state IDLE.
- start is ignored while in RUN or DONE (no queuing).
- err_count saturates naturally at 4 (max 4 vectors); the 3-bit width cannot wrap.
- dwell_cnt width is $clog2(DWELL). vec is 2 bits and never wraps within a run.
- Mid-run rst: at the next edge, all outputs and state return to reset values and any partial result is discarded.
- Reset values: a_out = 0, b_out = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_mask = 0, state = IDLE.
- Results (pass, err_count, fail_mask) persist in IDLE until the next accepted start or rst.

## Timing
- An accepted start sampled at edge T drives a_out/b_out = 00 from T+1 (registered, one-cycle latency).
- Vector k is held on cycles T+1+k·DWELL through T+(k+1)·DWELL.
- y_in is sampled on the last cycle of each dwell, giving the gate DWELL-1 cycles of settle.
- done is high on cycle T+1+4·DWELL; start-to-done latency is 4·DWELL+1 cycles.
- busy is high on cycles T+1 .. T+4·DWELL.
- A new start is accepted at earliest on the cycle after done (state IDLE).
- start coinciding with rst: rst wins and start is dropped.

## Structure
- Shared package gate_test_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - truth-table constants TT_AND = 4'b1000, TT_OR = 4'b1110, TT_XOR = 4'b0110, TT_NAND = 4'b0111, TT_NOR = 4'b0001.
- No sub-module: FSM, dwell counter and comparator stay flat in gate_exerciser.
- The existing or_gate is instantiated only in the bench, as the device under test.

## Test plan
- DWELL=4, exp_tt=TT_OR, correct or_gate as DUT, start pulse → a/b sequence 00, 01, 10, 11 with each vector held 4 cycles; done at start+17; pass=1, err_count=0, fail_mask=0000.
- DWELL=4, exp_tt=TT_OR, DUT replaced by an AND gate → fail_mask=0110, err_count=2, pass=0.
- DWELL=2, exp_tt=TT_OR, y_in tied to 0 → fail_mask=1110, err_count=3; done at start+9.
- During a run, pulse start again at start+5 → ignored; done still at start+17 and the results are identical to a single run.
- rst asserted at start+6 → next cycle busy=0, a_out=b_out=0, err_count=0, fail_mask=0, no done pulse; a fresh start then completes normally.
- Back-to-back runs: a passing run followed by a start with exp_tt=TT_NOR on the or_gate → pass clears on accept; the final result is fail_mask=1111, err_count=4, pass=0.

Source files
------------

// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate exerciser.
//   state_t  : exerciser FSM states (IDLE, RUN, DONE).
//   TT_*     : expected truth tables for common 2-input gates.
//              Bit index is {a,b}: bit0 = 00, bit1 = 01, bit2 = 10, bit3 = 11.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage

// File: rtl/gate_exerciser_if.sv
// Signal bundle between the gate exerciser and its environment.
//   start      : single-cycle run request
//   exp_tt     : expected truth table, latched on an accepted start
//   y_in       : output of the gate under test
//   a_out/b_out: registered inputs to the gate under test
//   busy/done  : run in progress / one-cycle end-of-run pulse
//   pass, err_count, fail_mask : run results, held until the next start
// Modports: master = the exerciser, slave = the surrounding environment.
interface gate_exerciser_if;

  logic       start;
  logic [3:0] exp_tt;
  logic       y_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;

  modport master (
    input  start, exp_tt, y_in,
    output a_out, b_out, busy, done, pass, err_count, fail_mask
  );

  modport slave (
    output start, exp_tt, y_in,
    input  a_out, b_out, busy, done, pass, err_count, fail_mask
  );

endinterface

// File: rtl/or_gate.sv
// Reference 2-input OR gate, used as a gate under test.
//   a, b : inputs
//   y    : a | b
module or_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a | b;

endmodule

// File: rtl/gate_exerciser.sv
// Stimulus/response stage for a 2-input combinational gate.
// After an accepted start it walks {a,b} through 00, 01, 10, 11, holding each
// vector for DWELL cycles, samples the gate output on the last cycle of each
// dwell and compares it against the latched truth table.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : gate_exerciser_if.master (start/exp_tt/y_in in; stimulus and
//          results out)
// Parameter DWELL: cycles each vector is held, legal 2..256.
module gate_exerciser #(
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  gate_exerciser_if.master    bus
);

  import gate_test_pkg::*;

  localparam int              CW        = $clog2(DWELL);
  localparam logic [CW-1:0]   DWELL_END = CW'(DWELL - 1);

  state_t        state;
  state_t        state_next;

  logic [CW-1:0] dwell_cnt;
  logic [1:0]    vec;
  logic [3:0]    tt;
  logic [1:0]    ab;
  logic          pass_q;
  logic [2:0]    err_q;
  logic [3:0]    mask_q;

  logic          sample;
  logic          mismatch;
  logic [2:0]    err_next;

  // Sample point: last cycle of the current vector's dwell.
  assign sample   = (state == RUN) && (dwell_cnt == DWELL_END);
  assign mismatch = (bus.y_in != tt[vec]);
  assign err_next = err_q + {2'b00, mismatch};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinationally assigned signal gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start)             state_next = RUN;
      RUN:     if (sample && vec == 2'd3) state_next = DONE;
      DONE:                               state_next = IDLE;
      default:                            state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      RUN:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: dwell counter, vector index, stimulus and result registers
  // ---------------------------------------------------------------------------
  // NOTE: the latched truth table is reset along with everything else; it is a
  // handful of flops, and a defined value keeps the compare path X-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt <= '0;
      vec       <= 2'd0;
      tt        <= 4'd0;
      ab        <= 2'd0;
      pass_q    <= 1'b0;
      err_q     <= 3'd0;
      mask_q    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            tt        <= bus.exp_tt;
            err_q     <= 3'd0;
            mask_q    <= 4'd0;
            pass_q    <= 1'b0;
            vec       <= 2'd0;
            dwell_cnt <= '0;
            ab        <= 2'd0;
          end
        end
        RUN: begin
          if (sample) begin
            err_q <= err_next;
            if (mismatch) mask_q[vec] <= 1'b1;
            dwell_cnt <= '0;
            if (vec == 2'd3) begin
              // Leaving RUN: park the gate inputs and publish the verdict so
              // pass is already valid during the done cycle.
              ab     <= 2'd0;
              pass_q <= (err_next == 3'd0);
            end else begin
              // Registered stimulus: the next vector appears on the cycle
              // after this dwell's sample point.
              vec <= vec + 2'd1;
              ab  <= vec + 2'd1;
            end
          end else begin
            dwell_cnt <= dwell_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.a_out     = ab[1];
  assign bus.b_out     = ab[0];
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_mask = mask_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed testbench for gate_exerciser. Two exercisers are instantiated:
// one with DWELL=4 driving a selectable gate (or_gate, AND, or constant 0),
// one with DWELL=2 whose y_in is tied to 0.
module tb_gate_exerciser;

  import gate_test_pkg::*;

  logic clk;
  logic rst;

  logic       sel;        // 0: drive/observe the DWELL=4 unit, 1: DWELL=2 unit
  logic       start_r;
  logic [3:0] exp_tt_r;
  logic [1:0] gate_sel;   // DWELL=4 unit: 0 = or_gate, 1 = AND, 2 = constant 0

  int passed;
  int total;

  gate_exerciser_if bus4 ();
  gate_exerciser_if bus2 ();

  gate_exerciser #(.DWELL(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.master));
  gate_exerciser #(.DWELL(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

  logic y_or4;
  or_gate u_or4 (.a(bus4.a_out), .b(bus4.b_out), .y(y_or4));

  assign bus4.start  = start_r & ~sel;
  assign bus2.start  = start_r & sel;
  assign bus4.exp_tt = exp_tt_r;
  assign bus2.exp_tt = exp_tt_r;
  assign bus4.y_in   = (gate_sel == 2'd0) ? y_or4 :
                       (gate_sel == 2'd1) ? (bus4.a_out & bus4.b_out) : 1'b0;
  assign bus2.y_in   = 1'b0;

  // Observation views: {busy, done, a, b} and {pass, err_count, fail_mask}.
  logic [3:0] ctl4, ctl2, ctl;
  logic [7:0] res4, res2, res;
  assign ctl4 = {bus4.busy, bus4.done, bus4.a_out, bus4.b_out};
  assign ctl2 = {bus2.busy, bus2.done, bus2.a_out, bus2.b_out};
  assign res4 = {bus4.pass, bus4.err_count, bus4.fail_mask};
  assign res2 = {bus2.pass, bus2.err_count, bus2.fail_mask};
  assign ctl  = sel ? ctl2 : ctl4;
  assign res  = sel ? res2 : res4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full run on the selected unit. Checks stimulus/busy/done every cycle,
  // results cleared on accept, final results on the done cycle, and that the
  // results persist in IDLE afterwards. Optionally re-pulses start at start+5.
  task automatic run_and_check(input string name, input logic [3:0] tt,
                               input logic [7:0] exp_res, input bit extra_start);
    int d;
    int last;
    logic [3:0] exp_ctl;
    d    = sel ? 2 : 4;
    last = 4 * d + 1;
    @(posedge clk); #1;
    start_r  = 1'b1;
    exp_tt_r = tt;
    @(posedge clk); #1;       // edge T has accepted the start
    start_r  = 1'b0;
    for (int n = 1; n <= last; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      if (n <= 4 * d) exp_ctl = {1'b1, 1'b0, 2'((n - 1) / d)};
      else            exp_ctl = 4'b0100;
      total++;
      if (ctl !== exp_ctl)
        $display("FAIL %s ctl cycle %0d: got %b want %b", name, n, ctl, exp_ctl);
      else passed++;
      if (n == 1) begin
        total++;
        if (res !== 8'h00)
          $display("FAIL %s cleared_on_accept: got %h want 00", name, res);
        else passed++;
      end
      if (n == last) begin
        total++;
        if (res !== exp_res)
          $display("FAIL %s result: got %b want %b", name, res, exp_res);
        else passed++;
      end
      if (extra_start && n == 4) begin
        start_r  = 1'b1;
        exp_tt_r = TT_AND;
      end
      if (extra_start && n == 5) start_r = 1'b0;
    end
    @(posedge clk); #1;
    total++;
    if (ctl !== 4'b0000 || res !== exp_res)
      $display("FAIL %s persist_idle: got ctl=%b res=%b want ctl=0000 res=%b",
               name, ctl, res, exp_res);
    else passed++;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start_r  = 1'b1;          // start coinciding with rst must be dropped
    exp_tt_r = TT_OR;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (ctl4 !== 4'b0000 || res4 !== 8'h00 || ctl2 !== 4'b0000 || res2 !== 8'h00)
      $display("FAIL reset_values: got %b %b %b %b want all zero", ctl4, res4, ctl2, res2);
    else passed++;
    rst     = 1'b0;
    start_r = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus4.busy !== 1'b0 || bus2.busy !== 1'b0)
      $display("FAIL start_with_rst: got busy4=%b busy2=%b want 0 0", bus4.busy, bus2.busy);
    else passed++;
  endtask

  task automatic test_or_pass();
    sel = 1'b0; gate_sel = 2'd0;
    run_and_check("or_pass", TT_OR, {1'b1, 3'd0, 4'b0000}, 1'b0);
  endtask

  task automatic test_and_fail();
    sel = 1'b0; gate_sel = 2'd1;
    run_and_check("and_fail", TT_OR, {1'b0, 3'd2, 4'b0110}, 1'b0);
    gate_sel = 2'd0;
  endtask

  task automatic test_dwell2_stuck0();
    sel = 1'b1;
    run_and_check("dwell2_stuck0", TT_OR, {1'b0, 3'd3, 4'b1110}, 1'b0);
    sel = 1'b0;
  endtask

  task automatic test_start_ignored();
    sel = 1'b0; gate_sel = 2'd0;
    run_and_check("start_ignored", TT_OR, {1'b1, 3'd0, 4'b0000}, 1'b1);
  endtask

  task automatic test_mid_reset();
    bit saw_done;
    sel = 1'b0; gate_sel = 2'd0;
    @(posedge clk); #1;
    start_r  = 1'b1;
    exp_tt_r = TT_NOR;        // vector 00 mismatches, so err is 1 before rst
    @(posedge clk); #1;
    start_r  = 1'b0;
    for (int n = 2; n <= 5; n++) begin
      @(posedge clk); #1;
    end
    total++;
    if (res4 !== {1'b0, 3'd1, 4'b0001})
      $display("FAIL mid_reset_partial: got %b want 00010001", res4);
    else passed++;
    rst = 1'b1;               // sampled at edge T+6
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (ctl4 !== 4'b0000 || res4 !== 8'h00)
      $display("FAIL mid_reset_clear: got ctl=%b res=%b want 0000 00000000", ctl4, res4);
    else passed++;
    saw_done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus4.done || bus4.busy) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0)
      $display("FAIL mid_reset_no_done: got activity=%b want 0", saw_done);
    else passed++;
    run_and_check("after_reset", TT_OR, {1'b1, 3'd0, 4'b0000}, 1'b0);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; gate_sel = 2'd0;
    run_and_check("b2b_first", TT_OR, {1'b1, 3'd0, 4'b0000}, 1'b0);
    run_and_check("b2b_nor", TT_NOR, {1'b0, 3'd4, 4'b1111}, 1'b0);
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    rst      = 1'b1;
    sel      = 1'b0;
    start_r  = 1'b0;
    exp_tt_r = 4'd0;
    gate_sel = 2'd0;
    test_reset();
    test_or_pass();
    test_and_fail();
    test_dwell2_stuck0();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
